// File: rtl/bus_pkg.sv
// bus_pkg: types and constants shared by the serial-bus ports (m_port, s_port).
//   m_port_state_t  : master-port FSM state encoding
//   BUS_ADDR_WIDTH  : default serialized address width
//   BUS_DATA_WIDTH  : default serialized data width
//   SER_W           : width of the shared serializer shift register
//   MODE_ADDR/DATA  : bus_mode encodings
//   RW_WRITE/READ   : bus_rw / m_rw encodings
package bus_pkg;
  localparam int BUS_ADDR_WIDTH = 16;
  localparam int BUS_DATA_WIDTH = 8;
  localparam int SER_W          = 16;

  localparam logic MODE_ADDR = 1'b0;
  localparam logic MODE_DATA = 1'b1;
  localparam logic RW_WRITE  = 1'b1;
  localparam logic RW_READ   = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE, ST_REQ, ST_ADDR, ST_GAP, ST_WDATA, ST_WAIT_ACK, ST_RDATA, ST_DONE
  } m_port_state_t;
endpackage

// File: rtl/bus_serializer.sv
// bus_serializer: loadable LSB-first PISO with a bit counter.
//   clk, rst_n  : clock, async active-low reset
//   i_load      : load i_data and the phase length (wins over i_shift)
//   i_data      : parallel word to serialize
//   i_len_m1    : number of bits in the phase minus one
//   i_shift     : advance one bit
//   o_bit       : current serial bit (register LSB)
//   o_last      : current bit is the last of the phase
module bus_serializer
  import bus_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [SER_W-1:0] i_data,
  input  logic [4:0]       i_len_m1,
  input  logic             i_shift,
  output logic             o_bit,
  output logic             o_last
);
  logic [SER_W-1:0] r_sr;
  logic [4:0]       r_cnt;
  logic [4:0]       r_len_m1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr     <= '0;
      r_cnt    <= '0;
      r_len_m1 <= '0;
    end else if (i_load) begin
      r_sr     <= i_data;
      r_cnt    <= '0;
      r_len_m1 <= i_len_m1;
    end else if (i_shift) begin
      r_sr <= {1'b0, r_sr[SER_W-1:1]};
      // Counter parks on the last index so an extra shift never overruns.
      if (!o_last) r_cnt <= r_cnt + 5'd1;
    end
  end

  assign o_bit  = r_sr[0];
  assign o_last = (r_cnt == r_len_m1);
endmodule

// File: rtl/m_port.sv
// m_port: master-side serial bus port. Accepts one parallel read/write,
// requests the bus, shifts address (and write data) out LSB-first, collects
// 8 read bits from the slave, and pulses m_done on completion.
//   master side : m_req/m_rw/m_addr/m_wdata in; m_ready/m_rdata/m_done/m_err out
//   bus side    : bus_req/bus_rw/bus_data_out/bus_data_out_valid/bus_mode out;
//                 bus_grant/bus_s_ready/bus_s_ack/bus_data_in/bus_data_in_valid in
// Optional: define M_PORT_TIMEOUT_EN to add an ACK_TIMEOUT-cycle watchdog in
// WAIT_ACK/RDATA that completes with m_err; otherwise m_err is tied to 0.
module m_port
  import bus_pkg::*;
#(
  parameter int ADDR_WIDTH  = BUS_ADDR_WIDTH,
  parameter int DATA_WIDTH  = BUS_DATA_WIDTH,
  parameter int ACK_TIMEOUT = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m_req,
  input  logic                  m_rw,
  input  logic [ADDR_WIDTH-1:0] m_addr,
  input  logic [DATA_WIDTH-1:0] m_wdata,
  output logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_rdata,
  output logic                  m_done,
  output logic                  m_err,
  output logic                  bus_req,
  input  logic                  bus_grant,
  input  logic                  bus_s_ready,
  input  logic                  bus_s_ack,
  output logic                  bus_rw,
  output logic                  bus_data_out,
  output logic                  bus_data_out_valid,
  output logic                  bus_mode,
  input  logic                  bus_data_in,
  input  logic                  bus_data_in_valid
);
  localparam int RXW = $clog2(DATA_WIDTH);

  m_port_state_t         r_state;
  logic                  r_ready, r_done, r_req, r_rw, r_valid, r_mode;
  logic [DATA_WIDTH-1:0] r_rdata, r_wdata, r_rx, w_rx_next;
  logic [4:0]            r_rx_cnt;
  logic                  r_rx_full, r_ack_seen;
  logic                  w_ser_load, w_ser_shift, w_ser_bit, w_ser_last;
  logic [SER_W-1:0]      w_ser_data;
  logic [4:0]            w_ser_len_m1;
  logic                  w_rx_take, w_rx_all, w_ack_any, w_timeout;

  // Address is loaded at accept; write data is loaded on the last address bit
  // so it is ready when WDATA starts.
  assign w_ser_load   = (r_state == ST_IDLE && m_req) || (r_state == ST_ADDR && w_ser_last);
  assign w_ser_data   = (r_state == ST_IDLE) ? SER_W'(m_addr) : SER_W'(r_wdata);
  assign w_ser_len_m1 = (r_state == ST_IDLE) ? 5'(ADDR_WIDTH-1) : 5'(DATA_WIDTH-1);
  assign w_ser_shift  = (r_state == ST_ADDR) || (r_state == ST_WDATA);

  bus_serializer u_ser (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_ser_load),
    .i_data   (w_ser_data),
    .i_len_m1 (w_ser_len_m1),
    .i_shift  (w_ser_shift),
    .o_bit    (w_ser_bit),
    .o_last   (w_ser_last)
  );

  // Read deserializer: the word including this cycle's bit, so completion can
  // publish it in the same edge that captures the 8th bit.
  assign w_rx_take = bus_data_in_valid && !r_rx_full;
  always_comb begin
    w_rx_next = r_rx;
    if (w_rx_take) w_rx_next[r_rx_cnt[RXW-1:0]] = bus_data_in;
  end
  assign w_rx_all  = r_rx_full || (w_rx_take && r_rx_cnt == 5'(DATA_WIDTH-1));
  assign w_ack_any = r_ack_seen || bus_s_ack;

`ifdef M_PORT_TIMEOUT_EN
  localparam int TOW = $clog2(ACK_TIMEOUT) + 1;
  logic [TOW-1:0] r_to_cnt;
  logic           r_err;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                        r_to_cnt <= '0;
    else if (r_state == ST_WAIT_ACK || r_state == ST_RDATA) r_to_cnt <= r_to_cnt + TOW'(1);
    else                                               r_to_cnt <= '0;
  end
  assign w_timeout = (r_to_cnt == TOW'(ACK_TIMEOUT-1));
  assign m_err     = r_err;
`else
  // Watchdog absent: constant-false, keeps ACK_TIMEOUT referenced.
  assign w_timeout = (ACK_TIMEOUT < 0);
  assign m_err     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_ready    <= 1'b1;
      r_done     <= 1'b0;
      r_req      <= 1'b0;
      r_rw       <= RW_READ;
      r_valid    <= 1'b0;
      r_mode     <= MODE_ADDR;
      r_rdata    <= '0;
      r_wdata    <= '0;
      r_rx       <= '0;
      r_rx_cnt   <= '0;
      r_rx_full  <= 1'b0;
      r_ack_seen <= 1'b0;
`ifdef M_PORT_TIMEOUT_EN
      r_err      <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
`ifdef M_PORT_TIMEOUT_EN
      r_err  <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: if (m_req) begin
          r_state    <= ST_REQ;
          r_ready    <= 1'b0;
          r_req      <= 1'b1;
          r_rw       <= m_rw;
          r_wdata    <= m_wdata;
          r_rx_cnt   <= '0;
          r_rx_full  <= 1'b0;
          r_ack_seen <= 1'b0;
        end
        ST_REQ: if (bus_grant && bus_s_ready) begin
          r_state <= ST_ADDR;
          r_valid <= 1'b1;
          r_mode  <= MODE_ADDR;
        end
        ST_ADDR: if (w_ser_last) begin
          r_state <= ST_GAP;
          r_valid <= 1'b0;
        end
        ST_GAP: begin
          r_mode <= MODE_DATA;
          if (r_rw == RW_WRITE) begin
            r_state <= ST_WDATA;
            r_valid <= 1'b1;
          end else begin
            r_state <= ST_RDATA;
          end
        end
        ST_WDATA: if (w_ser_last) begin
          r_state <= ST_WAIT_ACK;
          r_valid <= 1'b0;
        end
        ST_WAIT_ACK: if (bus_s_ack || w_timeout) begin
          r_state <= ST_DONE;
          r_done  <= 1'b1;
`ifdef M_PORT_TIMEOUT_EN
          r_err   <= !bus_s_ack;
`endif
        end
        ST_RDATA: begin
          r_rx <= w_rx_next;
          if (w_rx_take) begin
            if (r_rx_cnt == 5'(DATA_WIDTH-1)) r_rx_full <= 1'b1;
            else                              r_rx_cnt  <= r_rx_cnt + 5'd1;
          end
          if (bus_s_ack) r_ack_seen <= 1'b1;
          if (w_rx_all && w_ack_any) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
            r_rdata <= w_rx_next;
          end else if (w_timeout) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
`ifdef M_PORT_TIMEOUT_EN
            r_err   <= 1'b1;
`endif
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
          r_req   <= 1'b0;
          r_rw    <= RW_READ;
          r_mode  <= MODE_ADDR;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign m_ready            = r_ready;
  assign m_rdata            = r_rdata;
  assign m_done             = r_done;
  assign bus_req            = r_req;
  assign bus_rw             = r_rw;
  assign bus_data_out_valid = r_valid;
  assign bus_mode           = r_mode;
  assign bus_data_out       = r_valid & w_ser_bit;
endmodule
